// File: rtl/block_accumulator.sv
// Block accumulator: drains one product block from upstream and sums it.
// Optional clamped result outputs (res_sat/res_ovf) under BLOCK_ACC_SAT_EN.
module block_accumulator #(
    parameter int DATA_W      = 16,
    parameter int BLOCK_LEN   = 64,
    parameter int ACC_W       = DATA_W + $clog2(BLOCK_LEN),
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        blk_ready,
    output logic                        EN_blockRead,
    input  logic                        VALID_memVal,
    input  logic [DATA_W-1:0]           memVal_data,
    output logic                        busy,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [ACC_W-1:0]            res_sum,
    output logic [$clog2(BLOCK_LEN):0]  res_count,
    output logic                        err_short
`ifdef BLOCK_ACC_SAT_EN
    ,
    output logic [DATA_W-1:0]           res_sat,
    output logic                        res_ovf
`endif
);

    localparam int CNT_W = $clog2(BLOCK_LEN) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN);
    localparam logic [TMR_W-1:0] LAST_IDLE = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        COLLECT,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [ACC_W-1:0]  acc, acc_d;
    logic [CNT_W-1:0]  count, count_d;
    logic [TMR_W-1:0]  timer, timer_d;
    logic              err, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            timer <= '0;
            err   <= 1'b0;
        end else begin
            acc   <= acc_d;
            count <= count_d;
            timer <= timer_d;
            err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        acc_d   = acc;
        count_d = count;
        timer_d = timer;
        err_d   = err;
        unique case (state)
            IDLE: begin
                if (start && blk_ready) begin
                    state_d = REQ;
                    acc_d   = '0;
                    count_d = '0;
                    timer_d = '0;
                    err_d   = 1'b0;
                end
            end
            REQ, COLLECT: begin
                // A beat always restarts the idle timer; only gaps advance it.
                if (VALID_memVal) begin
                    acc_d   = acc + ACC_W'(memVal_data);
                    count_d = count + CNT_W'(1);
                    timer_d = '0;
                    state_d = (count_d == LAST_CNT) ? DONE : COLLECT;
                end else begin
                    timer_d = timer + TMR_W'(1);
                    if (timer == LAST_IDLE) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign EN_blockRead = (state == REQ);
    assign busy         = (state != IDLE);
    assign res_valid    = (state == DONE);
    assign res_sum      = acc;
    assign res_count    = count;
    assign err_short    = err;

`ifdef BLOCK_ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});

    assign res_ovf = (acc > SAT_MAX);
    assign res_sat = res_ovf ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
`endif

endmodule
